// File: rtl/fetch_unit_pkg.sv
// Shared types for the LC-3b fetch stage: machine word, buffered fetch entry,
// fetch FSM states and the sequential next-PC helper.
package fetch_unit_pkg;

  typedef logic [15:0] lc3b_word;

  typedef struct packed {
    lc3b_word instr;
    lc3b_word pc;
    lc3b_word pred_target;
    logic     pred_taken;
  } fetch_entry;

  typedef enum logic {
    ST_REQ    = 1'b0,
    ST_SQUASH = 1'b1
  } fetch_state_e;

  localparam lc3b_word   PC_STEP   = 16'd2;
  localparam logic [1:0] FIFO_FULL = 2'd2;

  // Fall-through PC; 16-bit wrap is intentional (16'hFFFE -> 16'h0000).
  function automatic lc3b_word next_seq_pc(input lc3b_word pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_unit_fifo.sv
// Two-entry in-order buffer between the fetch stage and decode.
// Slot 0 is always the head; flush outranks push and pop.
module fetch_fifo
  import fetch_unit_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic       i_pop,
  input  logic       i_flush,
  input  fetch_entry i_din,
  output logic [1:0] o_count,
  output fetch_entry o_head
);

  fetch_entry r_slot0;
  fetch_entry r_slot1;
  logic [1:0] r_count;
  logic       w_do_pop;
  logic       w_do_push;

  // Qualify requests so an empty pop or an overfilling push is ignored.
  always_comb begin
    w_do_pop  = 1'b0;
    w_do_push = 1'b0;
    if (i_pop && (r_count != 2'd0)) begin
      w_do_pop = 1'b1;
    end else begin
      w_do_pop = 1'b0;
    end
    if (i_push && ((r_count != FIFO_FULL) || w_do_pop)) begin
      w_do_push = 1'b1;
    end else begin
      w_do_push = 1'b0;
    end
  end

  // Slot shifting and occupancy tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot0 <= '0;
      r_slot1 <= '0;
      r_count <= 2'd0;
    end else if (i_flush) begin
      r_count <= 2'd0;
    end else begin
      case ({w_do_push, w_do_pop})
        2'b11: begin
          if (r_count == FIFO_FULL) begin
            r_slot0 <= r_slot1;
            r_slot1 <= i_din;
          end else begin
            r_slot0 <= i_din;
          end
        end
        2'b10: begin
          if (r_count == 2'd0) begin
            r_slot0 <= i_din;
          end else begin
            r_slot1 <= i_din;
          end
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_slot0 <= r_slot1;
          r_count <= r_count - 2'd1;
        end
        default: begin
          r_count <= r_count;
        end
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_slot0;

endmodule

// File: rtl/fetch_unit.sv
// LC-3b instruction fetch: owns the PC, issues one I-cache request at a time,
// follows BTB predictions and back-end redirects, and buffers results for decode.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter lc3b_word RESET_PC = 16'h0000
) (
  input  logic     clk,
  input  logic     reset,
  output lc3b_word fetch_pc,
  input  logic     btb_hit,
  input  lc3b_word btb_target,
  output logic     icache_read,
  output lc3b_word icache_address,
  input  logic     icache_resp,
  input  lc3b_word icache_rdata,
  input  logic     redirect,
  input  lc3b_word redirect_pc,
  output logic     out_valid,
  input  logic     out_ready,
  output lc3b_word out_instr,
  output lc3b_word out_pc,
  output lc3b_word out_pred_target,
  output logic     out_pred_taken
);

  fetch_state_e r_state;
  fetch_state_e w_state_nxt;
  lc3b_word     r_pc;
  lc3b_word     w_pc_nxt;
  lc3b_word     r_squash_addr;
  lc3b_word     w_squash_nxt;
  logic         w_read;
  logic         w_push;
  logic         w_pop;
  logic         w_flush;
  logic [1:0]   w_count;
  fetch_entry   w_din;
  fetch_entry   w_head;

  assign w_read = !reset && (((r_state == ST_REQ) && (w_count != FIFO_FULL))
                             || (r_state == ST_SQUASH));
  assign w_din  = '{instr: icache_rdata, pc: r_pc,
                    pred_target: btb_target, pred_taken: btb_hit};

  // Next-state, next-PC and buffer control; redirect outranks everything.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_squash_nxt = r_squash_addr;
    w_push       = 1'b0;
    w_pop        = out_valid && out_ready;
    w_flush      = 1'b0;
    if (redirect) begin
      w_flush  = 1'b1;
      w_pop    = 1'b0;
      w_pc_nxt = redirect_pc;
      case (r_state)
        ST_REQ: begin
          // An in-flight request cannot be cancelled; wait out its response.
          if (w_read && !icache_resp) begin
            w_squash_nxt = r_pc;
            w_state_nxt  = ST_SQUASH;
          end else begin
            w_state_nxt  = ST_REQ;
          end
        end
        ST_SQUASH: begin
          if (icache_resp) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt = ST_SQUASH;
          end
        end
        default: begin
          w_state_nxt = ST_REQ;
        end
      endcase
    end else begin
      case (r_state)
        ST_REQ: begin
          if (icache_resp && w_read) begin
            w_push   = 1'b1;
            w_pc_nxt = btb_hit ? btb_target : next_seq_pc(r_pc);
          end else begin
            w_push   = 1'b0;
          end
        end
        ST_SQUASH: begin
          if (icache_resp) begin
            w_state_nxt = ST_REQ;
          end else begin
            w_state_nxt = ST_SQUASH;
          end
        end
        default: begin
          w_state_nxt = ST_REQ;
        end
      endcase
    end
  end

  // State, PC and squash-address registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_REQ;
      r_pc          <= RESET_PC;
      r_squash_addr <= RESET_PC;
    end else begin
      r_state       <= w_state_nxt;
      r_pc          <= w_pc_nxt;
      r_squash_addr <= w_squash_nxt;
    end
  end

  fetch_fifo u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (w_flush),
    .i_din   (w_din),
    .o_count (w_count),
    .o_head  (w_head)
  );

  assign fetch_pc        = r_pc;
  assign icache_read     = w_read;
  assign icache_address  = (r_state == ST_SQUASH) ? r_squash_addr : r_pc;
  assign out_valid       = (w_count != 2'd0);
  assign out_instr       = w_head.instr;
  assign out_pc          = w_head.pc;
  assign out_pred_target = w_head.pred_target;
  assign out_pred_taken  = w_head.pred_taken;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit: one table row per clock cycle,
// plus hand-written reset-mid-request and restart sequences.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] fetch_pc;
  logic        btb_hit;
  logic [15:0] btb_target;
  logic        icache_read;
  logic [15:0] icache_address;
  logic        icache_resp;
  logic [15:0] icache_rdata;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_instr;
  logic [15:0] out_pc;
  logic [15:0] out_pred_target;
  logic        out_pred_taken;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(16'h0000)) dut (
    .clk             (clk),
    .reset           (reset),
    .fetch_pc        (fetch_pc),
    .btb_hit         (btb_hit),
    .btb_target      (btb_target),
    .icache_read     (icache_read),
    .icache_address  (icache_address),
    .icache_resp     (icache_resp),
    .icache_rdata    (icache_rdata),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instr       (out_instr),
    .out_pc          (out_pc),
    .out_pred_target (out_pred_target),
    .out_pred_taken  (out_pred_taken)
  );

  typedef struct {
    logic        hit;
    logic [15:0] tgt;
    logic        resp;
    logic [15:0] rdata;
    logic        redir;
    logic [15:0] rpc;
    logic        ready;
    logic [15:0] e_fpc;
    logic        e_rd;
    logic [15:0] e_addr;
    logic        e_val;
    logic [15:0] e_pc;
    logic [15:0] e_instr;
    logic        e_tk;
    logic [15:0] e_tgt;
  } vec_t;

  vec_t tbl[16];

  function automatic vec_t mk(
    input logic hit, input logic [15:0] tgt, input logic resp, input logic [15:0] rdata,
    input logic redir, input logic [15:0] rpc, input logic ready,
    input logic [15:0] e_fpc, input logic e_rd, input logic [15:0] e_addr, input logic e_val,
    input logic [15:0] e_pc, input logic [15:0] e_instr, input logic e_tk, input logic [15:0] e_tgt);
    vec_t v;
    v.hit = hit; v.tgt = tgt; v.resp = resp; v.rdata = rdata;
    v.redir = redir; v.rpc = rpc; v.ready = ready;
    v.e_fpc = e_fpc; v.e_rd = e_rd; v.e_addr = e_addr; v.e_val = e_val;
    v.e_pc = e_pc; v.e_instr = e_instr; v.e_tk = e_tk; v.e_tgt = e_tgt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    btb_hit = 1'b0; btb_target = 16'h0000; icache_resp = 1'b0; icache_rdata = 16'h0000;
    redirect = 1'b0; redirect_pc = 16'h0000; out_ready = 1'b0;
  endtask

  initial begin
    bit seen;
    //              hit tgt     resp rdata  redir rpc   rdy  fpc     rd   addr    val  pc      instr   tk   tgt
    tbl[0]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    tbl[1]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    tbl[2]  = mk(1'b0, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'h1234, 1'b0, 16'h0000);
    tbl[3]  = mk(1'b1, 16'h0010, 1'b1, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0010, 1'b0, 16'h0010, 1'b1, 16'h0000, 16'h1234, 1'b0, 16'h0000);
    tbl[4]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0010, 1'b1, 16'h0010, 1'b1, 16'h0002, 16'h5555, 1'b1, 16'h0010);
    tbl[5]  = mk(1'b1, 16'h0040, 1'b1, 16'hABCD, 1'b0, 16'h0000, 1'b1, 16'h0040, 1'b1, 16'h0040, 1'b1, 16'h0010, 16'hABCD, 1'b1, 16'h0040);
    tbl[6]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 16'hFFFE, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    tbl[7]  = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0100, 1'b0, 16'h0100, 1'b1, 16'h0040, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    tbl[8]  = mk(1'b0, 16'h0000, 1'b1, 16'h9999, 1'b0, 16'h0000, 1'b0, 16'h0100, 1'b1, 16'h0100, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    tbl[9]  = mk(1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, 16'h0000, 1'b0, 16'h0102, 1'b1, 16'h0102, 1'b1, 16'h0100, 16'h1111, 1'b0, 16'h0000);
    tbl[10] = mk(1'b0, 16'h0000, 1'b1, 16'h2222, 1'b1, 16'hFFFE, 1'b0, 16'hFFFE, 1'b1, 16'hFFFE, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    tbl[11] = mk(1'b0, 16'h0000, 1'b1, 16'h3333, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'hFFFE, 16'h3333, 1'b0, 16'h0000);
    tbl[12] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);
    tbl[13] = mk(1'b0, 16'h0000, 1'b1, 16'h4444, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 16'h0002, 1'b1, 16'h0000, 16'h4444, 1'b0, 16'h0000);
    tbl[14] = mk(1'b0, 16'h0000, 1'b1, 16'h5656, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b0, 16'h0004, 1'b1, 16'h0000, 16'h4444, 1'b0, 16'h0000);
    tbl[15] = mk(1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0300, 1'b0, 16'h0300, 1'b1, 16'h0300, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000);

    idle_inputs();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_read", {15'h0000, icache_read}, 16'h0000);
    chk("rst_fetch_pc", fetch_pc, 16'h0000);
    chk("rst_valid", {15'h0000, out_valid}, 16'h0000);
    chk("rst_instr", out_instr, 16'h0000);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      btb_hit = tbl[i].hit; btb_target = tbl[i].tgt;
      icache_resp = tbl[i].resp; icache_rdata = tbl[i].rdata;
      redirect = tbl[i].redir; redirect_pc = tbl[i].rpc; out_ready = tbl[i].ready;
      @(posedge clk);
      #1;
      idle_inputs();
      chk($sformatf("row%0d_fetch_pc", i), fetch_pc, tbl[i].e_fpc);
      chk($sformatf("row%0d_read", i), {15'h0000, icache_read}, {15'h0000, tbl[i].e_rd});
      chk($sformatf("row%0d_addr", i), icache_address, tbl[i].e_addr);
      chk($sformatf("row%0d_valid", i), {15'h0000, out_valid}, {15'h0000, tbl[i].e_val});
      if (tbl[i].e_val) begin
        chk($sformatf("row%0d_out_pc", i), out_pc, tbl[i].e_pc);
        chk($sformatf("row%0d_instr", i), out_instr, tbl[i].e_instr);
        chk($sformatf("row%0d_taken", i), {15'h0000, out_pred_taken}, {15'h0000, tbl[i].e_tk});
        chk($sformatf("row%0d_ptgt", i), out_pred_target, tbl[i].e_tgt);
      end
    end

    // Fill one entry at 16'h0300, then reset mid-request.
    icache_resp = 1'b1; icache_rdata = 16'h7777;
    @(posedge clk);
    #1;
    idle_inputs();
    chk("pre_rst_valid", {15'h0000, out_valid}, 16'h0001);
    chk("pre_rst_out_pc", out_pc, 16'h0300);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_rst_read", {15'h0000, icache_read}, 16'h0000);
    chk("mid_rst_valid", {15'h0000, out_valid}, 16'h0000);
    chk("mid_rst_out_pc", out_pc, 16'h0000);
    chk("mid_rst_instr", out_instr, 16'h0000);
    chk("mid_rst_fetch_pc", fetch_pc, 16'h0000);
    reset = 1'b0;

    // Fetch must restart from RESET_PC within a bounded number of cycles.
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (icache_read) begin
        seen = 1'b1;
        break;
      end
    end
    chk("restart_seen", {15'h0000, seen}, 16'h0001);
    chk("restart_addr", icache_address, 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the LC-3b pipeline, directly upstream of the BTB. It owns the program counter, presents it to the I-cache and the BTB each cycle, and selects the next PC from the BTB prediction (hit → target, else PC+2) or from a back-end redirect. Fetched instructions and their predictions go into a 2-entry buffer that feeds decode through a valid/ready handshake.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset.
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high.
- fetch_pc  out  16  current PC (lc3b_word), drives the BTB lookup.
- btb_hit  in  1  BTB hit for fetch_pc, same cycle (combinational lookup).
- btb_target  in  16  predicted target for fetch_pc, valid when btb_hit.
- icache_read  out  1  I-cache read request, held until icache_resp.
- icache_address  out  16  I-cache address.
- icache_resp  in  1  one-cycle response strobe.
- icache_rdata  in  16  instruction word, valid with icache_resp.
- redirect  in  1  mispredict/flush from the back end.
- redirect_pc  in  16  corrected PC, valid with redirect.
- out_valid  out  1  buffer head valid.
- out_ready  in  1  decode accepts head.
- out_instr, out_pc, out_pred_target  out  16 each  head entry fields.
- out_pred_taken  out  1  head entry was predicted taken.

## Operation
- Registers: pc, squash_addr, state {REQ, SQUASH}, 2-entry FIFO, count (0..2).
- fetch_pc = pc. icache_address = squash_addr in SQUASH, else pc.
- icache_read = !reset && ((state==REQ && count<2) || state==SQUASH). At most one request is outstanding, so a free slot always exists on response.
- REQ, icache_resp, no redirect: push {icache_rdata, pc, btb_hit, btb_target}; pc ← btb_hit ? btb_target : pc+2 (16-bit wrap, 16'hFFFE+2 = 16'h0000).
- REQ, redirect while icache_read=1 and no icache_resp: squash_addr ← pc, pc ← redirect_pc, state ← SQUASH.
- REQ, redirect with icache_resp the same cycle: response dropped, pc ← redirect_pc, stay REQ.
- REQ, redirect with icache_read=0: pc ← redirect_pc, stay REQ.
- SQUASH: hold icache_read on squash_addr; on icache_resp, discard the data and go to REQ. A redirect in SQUASH only updates pc (the latest redirect wins).
- Any redirect flushes the FIFO (count ← 0) and suppresses that cycle's pop and push. Redirect has priority over every other event.
- Pop when out_valid && out_ready. Push and pop in the same cycle leave count unchanged. A push never occurs with count==2.
- The BTB is sampled in the icache_resp cycle. pc is stable for the whole request, so the prediction matches the fetched word.
- Reset: pc=RESET_PC, state=REQ, count=0, out_valid=0, out_instr/out_pc/out_pred_target=0, out_pred_taken=0, icache_read=0. Reset mid-request abandons the request; the cache is expected to be reset with it.

## Timing
- Request is issued combinationally from state; icache_address is stable until icache_resp.
- icache_resp at edge N → out_valid=1 from cycle N+1 if the FIFO was empty (1-cycle latency).
- Back-to-back fetch: the next request is issued in the cycle after icache_resp with no bubble. Throughput is 1 instruction per cache response.
- Redirect at edge N → fetch_pc=redirect_pc in cycle N+1, out_valid=0 in N+1. If state was SQUASH, the new request starts the cycle after the stale icache_resp.
- The FIFO is full when count==2; icache_read drops until a pop.

## Structure
- Add `fetch_entry` struct {instr, pc, pred_target: lc3b_word; pred_taken: logic} to lc3b_types.
- Sub-module `fetch_fifo`: 2-entry, fetch_entry-wide, with push, pop, flush, count, head. All ports are synchronous. Flush has priority over push and pop.
- The FSM and PC logic live in fetch_unit.

## Test plan
- Reset then icache_resp after 2 cycles with rdata=16'h1234, btb_hit=0 → out_pc=16'h0000, out_instr=16'h1234, fetch_pc=16'h0002.
- pc=16'h0010, btb_hit=1, btb_target=16'h0040, icache_resp → entry out_pred_taken=1, out_pred_target=16'h0040; next fetch_pc=16'h0040.
- out_ready=0, three responses offered → count=2 after two; icache_read=0; one pop → icache_read=1 next cycle.
- Redirect to 16'h0100 while a request to 16'h0008 is outstanding → icache_address stays 16'h0008 until resp, that data is not pushed, then a request goes to 16'h0100 and out_valid=0 throughout.
- Redirect with icache_resp in the same cycle and count=1 → FIFO empty, response dropped, fetch_pc=16'h0100 next cycle.
- pc=16'hFFFE, no hit, resp → fetch_pc wraps to 16'h0000.
